// File: rtl/spw_link_pkg.sv
// SpaceWire link FSM shared types: state encodings, exit-cause codes, statistics slice indices.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package spw_link_pkg;

    typedef enum logic [5:0] {
        ST_ERROR_RESET = 6'b000000,
        ST_ERROR_WAIT  = 6'b000001,
        ST_READY       = 6'b000010,
        ST_STARTED     = 6'b000100,
        ST_CONNECTING  = 6'b001000,
        ST_RUN         = 6'b010000
    } link_state_t;

    typedef enum logic [2:0] {
        CAUSE_NONE     = 3'd0,
        CAUSE_RX_ERR   = 3'd1,
        CAUSE_CREDIT   = 3'd2,
        CAUSE_DISC     = 3'd3,
        CAUSE_CHAR     = 3'd4,
        CAUSE_TIMEOUT  = 3'd5,
        CAUSE_DISABLE  = 3'd6
    } exit_cause_t;

    // Slice positions inside err_stat; slice i counts exits with cause i+1.
    localparam int STAT_RX_ERR  = 0;
    localparam int STAT_CREDIT  = 1;
    localparam int STAT_DISC    = 2;
    localparam int STAT_CHAR    = 3;
    localparam int STAT_TIMEOUT = 4;
    localparam int STAT_N       = 5;

    function automatic exit_cause_t stat_cause(input int idx);
        return exit_cause_t'(idx + 1);
    endfunction

    // Fixed-priority selection among the exit events that apply in the current state.
    function automatic exit_cause_t pick_cause(input logic rx_err, input logic credit,
                                               input logic disc, input logic bad_char,
                                               input logic tmo, input logic dis);
        if (rx_err)        return CAUSE_RX_ERR;
        else if (credit)   return CAUSE_CREDIT;
        else if (disc)     return CAUSE_DISC;
        else if (bad_char) return CAUSE_CHAR;
        else if (tmo)      return CAUSE_TIMEOUT;
        else if (dis)      return CAUSE_DISABLE;
        else               return CAUSE_NONE;
    endfunction

endpackage

// File: rtl/spw_link_ctrl_if.sv
// Link-controller signal bundle: rx decoder events and host controls in, tx controls and status out.
// Latency: n/a (wires only).
// Backpressure: none; every event is a single-cycle strobe or a level.
interface spw_link_ctrl_if #(
    parameter int STAT_W = 8
);
    logic                  auto_start;
    logic                  link_start;
    logic                  link_disable;
    logic                  rx_error;
    logic                  rx_credit_error;
    logic                  rx_got_bit;
    logic                  rx_got_null;
    logic                  rx_got_fct;
    logic                  rx_got_nchar;
    logic                  rx_got_time_code;
    logic                  rx_resetn;
    logic                  enable_tx;
    logic                  send_null_tx;
    logic                  send_fct_tx;
    logic                  link_up;
    logic [5:0]            fsm_state;
    logic [2:0]            exit_cause;
    logic [5*STAT_W-1:0]   err_stat;

    modport master (
        output auto_start, link_start, link_disable, rx_error, rx_credit_error,
               rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code,
        input  rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up,
               fsm_state, exit_cause, err_stat
    );

    modport slave (
        input  auto_start, link_start, link_disable, rx_error, rx_credit_error,
               rx_got_bit, rx_got_null, rx_got_fct, rx_got_nchar, rx_got_time_code,
        output rx_resetn, enable_tx, send_null_tx, send_fct_tx, link_up,
               fsm_state, exit_cause, err_stat
    );
endinterface

// File: rtl/spw_link_timer.sv
// Saturating up-counter with synchronous clear and a terminal-value match flag.
// Latency: hit reflects the registered count (no input-to-output path).
// Backpressure: none; en pauses counting, clr wins over en.
module spw_link_timer #(
    parameter int CNT_W = 16
) (
    input  logic             pclk,
    input  logic             resetn,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             hit
);
    logic [CNT_W-1:0] cnt_q;

    // Count up while enabled, stick at all-ones, restart from zero on clear.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn)                   cnt_q <= '0;
        else if (clr)                  cnt_q <= '0;
        else if (en && (cnt_q != '1))  cnt_q <= cnt_q + CNT_W'(1);
    end

    assign hit = (cnt_q == term);
endmodule

// File: rtl/spw_link_ctrl.sv
// SpaceWire link-initialisation FSM with cycle-count timeouts; optional exit statistics via SPW_LINK_STATS_EN.
// Latency: every output is registered; an input event changes outputs one pclk edge later.
// Backpressure: none; rx events are strobes sampled every cycle, link_disable holds or drops the link.
module spw_link_ctrl
    import spw_link_pkg::*;
#(
    parameter int CNT_W     = 16,
    parameter int RESET_CYC = 640,
    parameter int WAIT_CYC  = 1280,
    parameter int DISC_CYC  = 85,
    parameter int STAT_W    = 8
) (
    input  logic           pclk,
    input  logic           resetn,
    spw_link_ctrl_if.slave lnk
);
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

    if (longint'(WAIT_CYC) > CNT_MAX || longint'(RESET_CYC) > CNT_MAX ||
        longint'(DISC_CYC) > CNT_MAX) begin : g_param_check
        $fatal(1, "spw_link_ctrl: a cycle parameter does not fit in CNT_W bits");
    end

    link_state_t      state_q, state_nxt;
    exit_cause_t      cause, exit_cause_q;
    logic             null_seen, bit_seen;
    logic             st_hit, disc_hit, disconnect;
    logic [CNT_W-1:0] st_term;
    logic             rx_resetn_q, enable_tx_q, send_null_q, send_fct_q, link_up_q;
    logic             bad_char_any, bad_char_data;

    // ERROR_RESET has its own dwell; every other state uses the wait/timeout length.
    assign st_term = (state_q == ST_ERROR_RESET) ? CNT_W'(RESET_CYC - 1) : CNT_W'(WAIT_CYC - 1);

    spw_link_timer #(.CNT_W(CNT_W)) u_state_tmr (
        .pclk   (pclk),
        .resetn (resetn),
        .clr    (state_nxt != state_q),
        .en     (1'b1),
        .term   (st_term),
        .hit    (st_hit)
    );

    // Disconnect timing only starts once a bit has been seen since leaving ERROR_RESET.
    spw_link_timer #(.CNT_W(CNT_W)) u_disc_tmr (
        .pclk   (pclk),
        .resetn (resetn),
        .clr    (lnk.rx_got_bit || !bit_seen),
        .en     (state_q != ST_ERROR_RESET),
        .term   (CNT_W'(DISC_CYC - 1)),
        .hit    (disc_hit)
    );

    assign disconnect    = disc_hit && (state_q != ST_ERROR_RESET);
    assign bad_char_data = lnk.rx_got_nchar || lnk.rx_got_time_code;
    assign bad_char_any  = bad_char_data || lnk.rx_got_fct;

    // Next state and exit cause; any error exit overrides forward progress.
    always_comb begin
        cause     = CAUSE_NONE;
        state_nxt = state_q;
        case (state_q)
            ST_ERROR_RESET: begin
                if (st_hit) state_nxt = ST_ERROR_WAIT;
            end
            ST_ERROR_WAIT: begin
                cause = pick_cause(lnk.rx_error, 1'b0, disconnect, bad_char_any, 1'b0, 1'b0);
                if (st_hit) state_nxt = ST_READY;
            end
            ST_READY: begin
                cause = pick_cause(lnk.rx_error, 1'b0, disconnect, bad_char_any, 1'b0, 1'b0);
                if (!lnk.link_disable && (lnk.link_start || (lnk.auto_start && null_seen)))
                    state_nxt = ST_STARTED;
            end
            ST_STARTED: begin
                cause = pick_cause(lnk.rx_error, 1'b0, disconnect, bad_char_any, st_hit,
                                   lnk.link_disable);
                if (null_seen) state_nxt = ST_CONNECTING;
            end
            ST_CONNECTING: begin
                cause = pick_cause(lnk.rx_error, 1'b0, disconnect, bad_char_data, st_hit,
                                   lnk.link_disable);
                if (lnk.rx_got_fct) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                cause = pick_cause(lnk.rx_error, lnk.rx_credit_error, disconnect, 1'b0, 1'b0,
                                   lnk.link_disable);
            end
            default: state_nxt = ST_ERROR_RESET;
        endcase
        if (cause != CAUSE_NONE) state_nxt = ST_ERROR_RESET;
    end

    // State register, latched rx flags, exit cause and registered output decode.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= ST_ERROR_RESET;
            exit_cause_q <= CAUSE_NONE;
            null_seen    <= 1'b0;
            bit_seen     <= 1'b0;
            rx_resetn_q  <= 1'b0;
            enable_tx_q  <= 1'b0;
            send_null_q  <= 1'b0;
            send_fct_q   <= 1'b0;
            link_up_q    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            if (cause != CAUSE_NONE) exit_cause_q <= cause;
            if (state_q == ST_ERROR_RESET) begin
                null_seen <= 1'b0;
                bit_seen  <= 1'b0;
            end else begin
                if (lnk.rx_got_null) null_seen <= 1'b1;
                if (lnk.rx_got_bit)  bit_seen  <= 1'b1;
            end
            rx_resetn_q <= (state_nxt != ST_ERROR_RESET);
            enable_tx_q <= state_nxt inside {ST_READY, ST_STARTED, ST_CONNECTING, ST_RUN};
            send_null_q <= state_nxt inside {ST_STARTED, ST_CONNECTING, ST_RUN};
            send_fct_q  <= state_nxt inside {ST_CONNECTING, ST_RUN};
            link_up_q   <= (state_nxt == ST_RUN);
        end
    end

    assign lnk.fsm_state    = state_q;
    assign lnk.exit_cause   = exit_cause_q;
    assign lnk.rx_resetn    = rx_resetn_q;
    assign lnk.enable_tx    = enable_tx_q;
    assign lnk.send_null_tx = send_null_q;
    assign lnk.send_fct_tx  = send_fct_q;
    assign lnk.link_up      = link_up_q;

`ifdef SPW_LINK_STATS_EN
    logic [STAT_W-1:0] stat_q [STAT_N];

    // One saturating counter per counted exit cause; only resetn clears them.
    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < STAT_N; i++) stat_q[i] <= '0;
        end else begin
            for (int i = 0; i < STAT_N; i++)
                if ((cause == stat_cause(i)) && (stat_q[i] != '1))
                    stat_q[i] <= stat_q[i] + STAT_W'(1);
        end
    end

    for (genvar g = 0; g < STAT_N; g++) begin : g_stat_out
        assign lnk.err_stat[g*STAT_W +: STAT_W] = stat_q[g];
    end
`else
    assign lnk.err_stat = '0;
`endif

endmodule

// File: tb/tb_spw_link_ctrl.sv
// Bench for spw_link_ctrl: directed table, hand sequences, and randomized traffic against a behavioural model.
// Latency: checks sample 1 time unit after each rising pclk edge.
// Backpressure: n/a.
module tb_spw_link_ctrl;
    import spw_link_pkg::*;

    localparam int STAT_W    = 8;
    localparam int RESET_CYC = 640;
    localparam int WAIT_CYC  = 1280;
    localparam int DISC_CYC  = 85;

    localparam logic [5:0] S_ER = 6'b000000, S_EW = 6'b000001, S_RD = 6'b000010;
    localparam logic [5:0] S_ST = 6'b000100, S_CN = 6'b001000, S_RUN = 6'b010000;

    logic pclk   = 1'b0;
    logic resetn = 1'b0;

    spw_link_ctrl_if #(.STAT_W(STAT_W)) lnk ();

    spw_link_ctrl #(
        .CNT_W(16), .RESET_CYC(RESET_CYC), .WAIT_CYC(WAIT_CYC),
        .DISC_CYC(DISC_CYC), .STAT_W(STAT_W)
    ) dut (
        .pclk   (pclk),
        .resetn (resetn),
        .lnk    (lnk.slave)
    );

    always #5 pclk = ~pclk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // States by index: 0 ER, 1 EW, 2 READY, 3 STARTED, 4 CONNECTING, 5 RUN.
    int m_st, m_cyc, m_entered, m_last_bit, m_cause;
    bit m_null, m_bit;
    int m_stat [5];

    function automatic logic [5:0] st_code(input int s);
        case (s)
            0: return 6'b000000;
            1: return 6'b000001;
            2: return 6'b000010;
            3: return 6'b000100;
            4: return 6'b001000;
            default: return 6'b010000;
        endcase
    endfunction

    function automatic void model_reset();
        m_st = 0; m_cyc = 0; m_entered = 0; m_last_bit = 0; m_cause = 0;
        m_null = 0; m_bit = 0;
        for (int k = 0; k < 5; k++) m_stat[k] = 0;
    endfunction

    function automatic void model_step();
        int  n, dwell, c, nxt;
        bit  disc, badc, tmo;
        m_cyc++;
        n     = m_cyc;
        dwell = n - m_entered;
        disc  = (m_st != 0) && m_bit && ((n - m_last_bit) == DISC_CYC);
        if (m_st >= 1 && m_st <= 3)
            badc = lnk.rx_got_fct || lnk.rx_got_nchar || lnk.rx_got_time_code;
        else if (m_st == 4)
            badc = lnk.rx_got_nchar || lnk.rx_got_time_code;
        else
            badc = 0;
        tmo = (m_st == 3 || m_st == 4) && (dwell == WAIT_CYC);
        c = 0;
        if (m_st != 0) begin
            if (lnk.rx_error)                           c = 1;
            else if (m_st == 5 && lnk.rx_credit_error)  c = 2;
            else if (disc)                              c = 3;
            else if (badc)                              c = 4;
            else if (tmo)                               c = 5;
            else if (m_st >= 3 && lnk.link_disable)     c = 6;
        end
        nxt = m_st;
        if (c != 0) nxt = 0;
        else begin
            case (m_st)
                0: if (dwell == RESET_CYC) nxt = 1;
                1: if (dwell == WAIT_CYC) nxt = 2;
                2: if (!lnk.link_disable && (lnk.link_start || (lnk.auto_start && m_null))) nxt = 3;
                3: if (m_null) nxt = 4;
                4: if (lnk.rx_got_fct) nxt = 5;
                default: ;
            endcase
        end
        if (c != 0) begin
            m_cause = c;
            if (c <= 5 && m_stat[c-1] < (1 << STAT_W) - 1) m_stat[c-1]++;
        end
        if (nxt != m_st) m_entered = n;
        if (m_st == 0) begin
            m_null = 0;
            m_bit  = 0;
        end else begin
            if (lnk.rx_got_null) m_null = 1;
            if (lnk.rx_got_bit) begin
                m_bit      = 1;
                m_last_bit = n;
            end
        end
        m_st = nxt;
    endfunction

    function automatic logic [63:0] model_out();
        logic [5*STAT_W-1:0] es;
        logic [2:0]          cz;
        es = '0;
`ifdef SPW_LINK_STATS_EN
        for (int k = 0; k < 5; k++) es[k*STAT_W +: STAT_W] = STAT_W'(m_stat[k]);
`endif
        cz = 3'(m_cause);
        return 64'({es, st_code(m_st), cz, (m_st != 0), (m_st >= 2), (m_st >= 3),
                    (m_st >= 4), (m_st == 5)});
    endfunction

    function automatic logic [63:0] dut_out();
        return 64'({lnk.err_stat, lnk.fsm_state, lnk.exit_cause, lnk.rx_resetn, lnk.enable_tx,
                    lnk.send_null_tx, lnk.send_fct_tx, lnk.link_up});
    endfunction

    // Cycle-by-cycle comparison of every output against the model.
    always begin
        @(posedge pclk);
        if (!resetn) model_reset();
        else         model_step();
        #1;
        check($sformatf("model cyc%0d", m_cyc), dut_out(), model_out());
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge pclk);
            #1;
        end
    endtask

    task automatic clr_pulses();
        lnk.link_start = 0; lnk.rx_error = 0; lnk.rx_credit_error = 0;
        lnk.rx_got_null = 0; lnk.rx_got_fct = 0; lnk.rx_got_nchar = 0;
        lnk.rx_got_time_code = 0;
    endtask

    task automatic wait_state(input logic [5:0] target, input int budget, input string name);
        int k;
        k = 0;
        while (lnk.fsm_state !== target && k < budget) begin
            tick(1);
            k++;
        end
        check(name, lnk.fsm_state, target);
    endtask

    task automatic goto_run(input string name);
        wait_state(S_RD, 2500, {name, " ready"});
        lnk.link_start = 1;  tick(1); lnk.link_start = 0;
        lnk.rx_got_null = 1; tick(1); lnk.rx_got_null = 0;
        tick(1);
        lnk.rx_got_fct = 1;  tick(1); lnk.rx_got_fct = 0;
        check({name, " run"}, lnk.fsm_state, S_RUN);
    endtask

    typedef struct {
        logic       ls, nul, fct, cred;
        int         n;
        logic [5:0] st;
        logic [2:0] cause;
        logic       up, fct_tx;
    } vec_t;

    vec_t tbl [8];
    int   quiet;

    initial begin
        tbl[0] = '{ls:1'b1, nul:1'b0, fct:1'b0, cred:1'b0, n:1,  st:S_ST,  cause:3'd0, up:1'b0, fct_tx:1'b0};
        tbl[1] = '{ls:1'b0, nul:1'b0, fct:1'b0, cred:1'b0, n:9,  st:S_ST,  cause:3'd0, up:1'b0, fct_tx:1'b0};
        tbl[2] = '{ls:1'b0, nul:1'b1, fct:1'b0, cred:1'b0, n:1,  st:S_ST,  cause:3'd0, up:1'b0, fct_tx:1'b0};
        tbl[3] = '{ls:1'b0, nul:1'b0, fct:1'b0, cred:1'b0, n:1,  st:S_CN,  cause:3'd0, up:1'b0, fct_tx:1'b1};
        tbl[4] = '{ls:1'b0, nul:1'b0, fct:1'b0, cred:1'b0, n:19, st:S_CN,  cause:3'd0, up:1'b0, fct_tx:1'b1};
        tbl[5] = '{ls:1'b0, nul:1'b0, fct:1'b1, cred:1'b0, n:1,  st:S_RUN, cause:3'd0, up:1'b1, fct_tx:1'b1};
        tbl[6] = '{ls:1'b0, nul:1'b0, fct:1'b0, cred:1'b0, n:30, st:S_RUN, cause:3'd0, up:1'b1, fct_tx:1'b1};
        tbl[7] = '{ls:1'b0, nul:1'b0, fct:1'b0, cred:1'b1, n:1,  st:S_ER,  cause:3'd2, up:1'b0, fct_tx:1'b0};

        lnk.auto_start = 0; lnk.link_disable = 0; lnk.rx_got_bit = 1;
        clr_pulses();
        model_reset();

        // Reset values before any clock edge.
        #2;
        check("rst state", lnk.fsm_state, S_ER);
        check("rst rx_resetn", lnk.rx_resetn, 1'b0);
        check("rst enable_tx", lnk.enable_tx, 1'b0);
        check("rst send_null", lnk.send_null_tx, 1'b0);
        check("rst send_fct", lnk.send_fct_tx, 1'b0);
        check("rst link_up", lnk.link_up, 1'b0);
        check("rst exit_cause", lnk.exit_cause, 3'd0);
        check("rst err_stat", lnk.err_stat, '0);

        @(posedge pclk); @(posedge pclk); #4;
        resetn = 1;

        // Startup timing: ERROR_WAIT after 640 edges, READY after 1920.
        tick(RESET_CYC - 1);
        check("er hold 639", lnk.fsm_state, S_ER);
        tick(1);
        check("ew at 640", lnk.fsm_state, S_EW);
        check("ew rx_resetn", lnk.rx_resetn, 1'b1);
        tick(WAIT_CYC - 1);
        check("ew hold", lnk.fsm_state, S_EW);
        tick(1);
        check("ready at 1920", lnk.fsm_state, S_RD);
        check("ready enable_tx", lnk.enable_tx, 1'b1);
        tick(50);
        check("ready stays", lnk.fsm_state, S_RD);

        // Directed start-up to RUN, then a credit error.
        for (int i = 0; i < 8; i++) begin
            lnk.link_start = tbl[i].ls; lnk.rx_got_null = tbl[i].nul;
            lnk.rx_got_fct = tbl[i].fct; lnk.rx_credit_error = tbl[i].cred;
            tick(1);
            clr_pulses();
            if (tbl[i].n > 1) tick(tbl[i].n - 1);
            check($sformatf("vec%0d state", i), lnk.fsm_state, tbl[i].st);
            check($sformatf("vec%0d cause", i), lnk.exit_cause, tbl[i].cause);
            check($sformatf("vec%0d link_up", i), lnk.link_up, tbl[i].up);
            check($sformatf("vec%0d send_fct", i), lnk.send_fct_tx, tbl[i].fct_tx);
        end

        // STARTED without a NULL times out after exactly 1280 cycles.
        wait_state(S_RD, 2500, "tmo ready");
        lnk.link_start = 1; tick(1); lnk.link_start = 0;
        check("tmo started", lnk.fsm_state, S_ST);
        tick(WAIT_CYC - 1);
        check("tmo hold", lnk.fsm_state, S_ST);
        tick(1);
        check("tmo exit", lnk.fsm_state, S_ER);
        check("tmo cause", lnk.exit_cause, 3'd5);

        // Disconnect 85 cycles after the last bit strobe.
        goto_run("disc");
        tick(5);
        lnk.rx_got_bit = 0;
        tick(DISC_CYC - 1);
        check("disc hold", lnk.fsm_state, S_RUN);
        tick(1);
        check("disc exit", lnk.fsm_state, S_ER);
        check("disc cause", lnk.exit_cause, 3'd3);
`ifdef SPW_LINK_STATS_EN
        check("stat disc", lnk.err_stat[STAT_DISC*STAT_W +: STAT_W], 8'd1);
        check("stat credit", lnk.err_stat[STAT_CREDIT*STAT_W +: STAT_W], 8'd1);
        check("stat timeout", lnk.err_stat[STAT_TIMEOUT*STAT_W +: STAT_W], 8'd1);
`else
        check("stat off", lnk.err_stat, '0);
`endif
        lnk.rx_got_bit = 1;

        // rx_error beats link_disable in the same cycle.
        goto_run("both");
        lnk.rx_error = 1; lnk.link_disable = 1;
        tick(1);
        clr_pulses(); lnk.link_disable = 0;
        check("both exit", lnk.fsm_state, S_ER);
        check("both cause", lnk.exit_cause, 3'd1);

        // N-Char during ERROR_WAIT is unexpected.
        wait_state(S_EW, 1000, "nchar ew");
        tick(3);
        lnk.rx_got_nchar = 1; tick(1); lnk.rx_got_nchar = 0;
        check("nchar exit", lnk.fsm_state, S_ER);
        check("nchar cause", lnk.exit_cause, 3'd4);

        // Asynchronous reset mid-RUN takes effect before the next edge.
        goto_run("arst");
        @(posedge pclk); #3;
        resetn = 0;
        #1;
        check("arst state", lnk.fsm_state, S_ER);
        check("arst rx_resetn", lnk.rx_resetn, 1'b0);
        check("arst enable_tx", lnk.enable_tx, 1'b0);
        check("arst send_null", lnk.send_null_tx, 1'b0);
        check("arst link_up", lnk.link_up, 1'b0);
        check("arst cause", lnk.exit_cause, 3'd0);
        @(posedge pclk); #4;
        resetn = 1;
        tick(1);

        // Randomized traffic; event rates depend on where the link is so that all states get visited.
        quiet = 0;
        for (int i = 0; i < 15000; i++) begin
            clr_pulses();
            if (quiet > 0) begin
                quiet--;
                lnk.rx_got_bit = 0;
            end else begin
                lnk.rx_got_bit = ($urandom_range(99) < 90);
                if ($urandom_range(2999) == 0) quiet = $urandom_range(120, 60);
            end
            lnk.rx_got_null = ($urandom_range(99) < 5);
            lnk.link_start  = ($urandom_range(99) < 2);
            if (m_st <= 2) begin
                lnk.rx_error         = ($urandom_range(7999) == 0);
                lnk.rx_got_fct       = ($urandom_range(7999) == 0);
                lnk.rx_got_nchar     = ($urandom_range(7999) == 0);
                lnk.rx_got_time_code = ($urandom_range(7999) == 0);
                lnk.rx_credit_error  = ($urandom_range(99) == 0);
            end else begin
                lnk.rx_error         = ($urandom_range(2999) == 0);
                lnk.rx_credit_error  = ($urandom_range(2999) == 0);
                lnk.rx_got_fct       = ($urandom_range(99) < 3);
                lnk.rx_got_nchar     = (m_st == 5) ? ($urandom_range(9) == 0) : ($urandom_range(499) == 0);
                lnk.rx_got_time_code = ($urandom_range(499) == 0);
            end
            if (lnk.link_disable) lnk.link_disable = ($urandom_range(49) != 0);
            else                  lnk.link_disable = ($urandom_range(999) == 0);
            if ($urandom_range(499) == 0) lnk.auto_start = ~lnk.auto_start;
            tick(1);
        end
        clr_pulses();
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
